// File: rtl/dpi_sample_pkg.sv
// Shared types, mode encodings and the channel slice helper
// for the buffered sample exporter.
package dpi_sample_pkg;

    localparam int NUM_CH_D = 7;
    localparam int CH_W_D   = 64;
    localparam int TS_W_D   = 32;
    localparam int PAY_W_D  = NUM_CH_D * CH_W_D;

    localparam logic MODE_ALL    = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    typedef struct packed {
        logic [TS_W_D-1:0]  ts;
        logic [PAY_W_D-1:0] payload;
    } rec_t;

    // Channel k of width w from a payload zero-extended to the default width.
    function automatic logic [CH_W_D-1:0] ch_slice(
        input logic [PAY_W_D-1:0] data,
        input int unsigned        k,
        input int unsigned        w
    );
        logic [PAY_W_D-1:0] s;
        logic [CH_W_D-1:0]  m;
        s = data >> (k * w);
        if (w >= CH_W_D) m = '1;
        else m = (CH_W_D'(1) << w) - CH_W_D'(1);
        return s[CH_W_D-1:0] & m;
    endfunction

endpackage

// File: rtl/dpi_sample_buffer_fifo.sv
// Generic first-word-fall-through FIFO with occupancy output.
// Caller guarantees no push into a full FIFO unless popping.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;

    assign o_valid = (r_level != '0);
    assign w_pop   = i_pop & o_valid;
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_level = r_level;

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (i_push && !w_pop)      r_level <= r_level + 1'b1;
            else if (!i_push && w_pop) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/dpi_sample_buffer.sv
// Timestamped channel snapshotter with change detection, a drop
// counter and an FWFT record buffer drained by valid/ready.
module dpi_sample_buffer
    import dpi_sample_pkg::*;
#(
    parameter int NUM_CH = 7,
    parameter int CH_W   = 64,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 32,
    parameter int DROP_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       mode,
    input  logic [NUM_CH-1:0]          ch_mask,
    input  logic [NUM_CH*CH_W-1:0]     sig_in,
    input  logic                       clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*CH_W-1:0]     out_data,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int PW = NUM_CH * CH_W;
    localparam int RW = TS_W + PW;
    localparam int LW = $clog2(DEPTH+1);

    logic [TS_W-1:0]   r_ts;
    logic [PW-1:0]     r_ref;
    logic              r_first;
    logic [DROP_W-1:0] r_drop;

    logic [PW-1:0] w_diff;
    logic          w_chg;
    logic          w_cap;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_full;
    logic [RW-1:0] w_rd;

    always_comb begin
        w_diff = sig_in ^ r_ref;
        w_chg  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_mask[k] && |ch_slice(PAY_W_D'(w_diff), unsigned'(k), CH_W))
                w_chg = 1'b1;
        end
    end

    assign w_cap  = en & ((mode == MODE_ALL) | r_first | w_chg);
    assign w_full = (level == LW'(DEPTH));
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_cap & (!w_full | w_pop);
    assign w_drop = w_cap & !w_push;

    sample_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  ({r_ts, sig_in}),
        .i_pop   (w_pop),
        .o_valid (out_valid),
        .o_data  (w_rd),
        .o_level (level)
    );

    assign out_ts   = w_rd[RW-1:PW];
    assign out_data = w_rd[PW-1:0];
    assign drop_cnt = r_drop;

    // A drop leaves ref/first alone so the change is seen again next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts    <= '0;
            r_ref   <= '0;
            r_first <= 1'b1;
            r_drop  <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_push) begin
                r_ref   <= sig_in;
                r_first <= 1'b0;
            end
            if (clr)
                r_drop <= '0;
            else if (w_drop && r_drop != '1)
                r_drop <= r_drop + 1'b1;
        end
    end

endmodule

// File: tb/tb_dpi_sample_buffer.sv
// Self-checking bench: queue-based reference model plus directed
// literal checks and a randomized phase.
module tb_dpi_sample_buffer;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int DEP = 4;
    localparam int TW  = 8;
    localparam int DW  = 4;
    localparam int PW  = NCH * CW;
    localparam int DMAX = (1 << DW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic [1:0]    ch_mask = '0;
    logic [PW-1:0] sig_in = '0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic [TW-1:0] out_ts;
    logic [2:0]    level;
    logic [DW-1:0] drop_cnt;

    dpi_sample_buffer #(
        .NUM_CH (NCH),
        .CH_W   (CW),
        .DEPTH  (DEP),
        .TS_W   (TW),
        .DROP_W (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .sig_in    (sig_in),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TW-1:0] ts;
        logic [PW-1:0] d;
    } mrec_t;

    mrec_t   q[$];
    int      m_ts;
    int      m_ref;
    bit      m_first;
    int      m_drop;
    int      checks = 0;
    int      errors = 0;
    bit      run = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_ts    = 0;
        m_ref   = 0;
        m_first = 1;
        m_drop  = 0;
    endtask

    function automatic bit m_chg();
        for (int k = 0; k < NCH; k++) begin
            int a, b;
            a = (int'(sig_in) >> (k * CW)) & 'hff;
            b = (m_ref >> (k * CW)) & 'hff;
            if (ch_mask[k] && a != b) return 1;
        end
        return 0;
    endfunction

    // One clock: decide from current inputs, update model at the edge.
    task automatic tick();
        bit cap, pop, push;
        cap  = en && (mode == 1'b0 || m_first || m_chg());
        pop  = (q.size() > 0) && out_ready;
        push = cap && (q.size() < DEP || pop);
        @(posedge clock);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back('{ts: TW'(m_ts), d: sig_in});
            m_ref   = int'(sig_in);
            m_first = 0;
        end
        if (clr) m_drop = 0;
        else if (cap && !push && m_drop < DMAX) m_drop++;
        m_ts = (m_ts + 1) % (1 << TW);
        #2;
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (run) begin
            chk("valid", 64'(out_valid), 64'(q.size() != 0));
            chk("level", 64'(level), 64'(q.size()));
            chk("drop", 64'(drop_cnt), 64'(m_drop));
            if (q.size() > 0) begin
                chk("data", 64'(out_data), 64'(q[0].d));
                chk("ts", 64'(out_ts), 64'(q[0].ts));
            end
        end
    end

    initial begin
        m_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        run = 1;

        // every-cycle capture, consumer always ready
        en = 1; mode = 0; out_ready = 1; sig_in = 16'h1234;
        chk("s1_valid0", 64'(out_valid), 64'd0);
        tick();
        chk("s1_valid1", 64'(out_valid), 64'd1);
        chk("s1_ts0", 64'(out_ts), 64'd0);
        chk("s1_d0", 64'(out_data), 64'h1234);
        tick();
        chk("s1_ts1", 64'(out_ts), 64'd1);
        tick();
        chk("s1_ts2", 64'(out_ts), 64'd2);
        chk("s1_drop", 64'(drop_cnt), 64'd0);
        en = 0;
        tick();
        chk("s1_empty", 64'(level), 64'd0);

        // change mode with channel 1 masked out
        do_reset();
        en = 1; mode = 1; ch_mask = 2'b01; sig_in = 16'h0011;
        tick();
        chk("s2_first", 64'(out_data), 64'h0011);
        tick();
        chk("s2_nocap", 64'(level), 64'd0);
        sig_in = 16'h5511;
        tick();
        chk("s2_masked", 64'(level), 64'd0);
        sig_in = 16'h5512;
        tick();
        chk("s2_chg", 64'(out_data), 64'h5512);
        chk("s2_chg_ts", 64'(out_ts), 64'd3);

        // overflow with stalled consumer
        do_reset();
        en = 1; mode = 0; out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            sig_in = 16'hA000 + 16'(i);
            tick();
        end
        chk("s3_level", 64'(level), 64'd4);
        chk("s3_drop", 64'(drop_cnt), 64'd2);
        chk("s3_head", 64'(out_data), 64'hA000);

        // push into full FIFO while popping
        out_ready = 1; sig_in = 16'hB000;
        tick();
        chk("s4_level", 64'(level), 64'd4);
        chk("s4_drop", 64'(drop_cnt), 64'd2);
        chk("s4_head", 64'(out_data), 64'hA001);
        chk("s4_ts", 64'(out_ts), 64'd1);

        // drop counter saturation, then clear beating a drop
        out_ready = 0;
        repeat (20) tick();
        chk("sat_drop", 64'(drop_cnt), 64'(DMAX));
        clr = 1;
        tick();
        chk("sat_clr", 64'(drop_cnt), 64'd0);
        clr = 0;

        // change mode, pending change held while full
        do_reset();
        en = 1; mode = 1; ch_mask = 2'b11; out_ready = 0;
        sig_in = 16'h0000; tick();
        sig_in = 16'h0100; tick();
        sig_in = 16'h0200; tick();
        sig_in = 16'h0000; tick();
        chk("s5_full", 64'(level), 64'd4);
        sig_in = 16'h0001;
        tick();
        tick();
        chk("s5_drop", 64'(drop_cnt), 64'd2);
        out_ready = 1;
        tick();
        chk("s5_lvl", 64'(level), 64'd4);
        chk("s5_drop2", 64'(drop_cnt), 64'd2);
        out_ready = 0; sig_in = 16'h0002; clr = 1;
        tick();
        chk("s5_clr", 64'(drop_cnt), 64'd0);
        clr = 0; en = 0; out_ready = 1;
        repeat (3) tick();
        chk("s5_late", 64'(out_data), 64'h0001);
        chk("s5_late_ts", 64'(out_ts), 64'd6);
        tick();

        // asynchronous reset mid-stream
        do_reset();
        en = 1; mode = 0; out_ready = 0; sig_in = 16'h0303;
        repeat (3) tick();
        chk("s6_lvl3", 64'(level), 64'd3);
        do_reset();
        tick();
        chk("s6_ts0", 64'(out_ts), 64'd0);
        chk("s6_lvl1", 64'(level), 64'd1);

        // randomized traffic
        for (int blk = 0; blk < 10; blk++) begin
            int rdy_bias;
            rdy_bias = $urandom_range(0, 3);
            for (int i = 0; i < 50; i++) begin
                en        = ($urandom_range(0, 3) != 0);
                mode      = 1'($urandom_range(0, 1));
                ch_mask   = 2'($urandom_range(0, 3));
                sig_in    = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
                clr       = ($urandom_range(0, 15) == 0);
                out_ready = ($urandom_range(0, 3) < rdy_bias);
                tick();
            end
        end

        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
